// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K&S processor: sequences fetch, decode and
// execute phases and drives Moore data-path strobes from the current state.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD_RD, S_LOAD_WR, S_STORE,
    S_ALU, S_MOVE, S_BRANCH, S_HALT
  } state_t;

  state_t state_q, state_d;

  // Unsigned overflow is latched by the data path but never steers branching.
  logic unused_uov;
  assign unused_uov = unsigned_overflow;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                       state_d = S_LOAD_RD;
          I_STORE:                      state_d = S_STORE;
          I_MOVE:                       state_d = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:    state_d = S_ALU;
          I_HALT:                       state_d = S_HALT;
          I_BRANCH:                     state_d = S_BRANCH;
          I_BZERO:  if (zero_op)          state_d = S_BRANCH;
          I_BNZERO: if (!zero_op)         state_d = S_BRANCH;
          I_BNEG:   if (neg_op)           state_d = S_BRANCH;
          I_BNNEG:  if (!neg_op)          state_d = S_BRANCH;
          I_BOV:    if (signed_overflow)  state_d = S_BRANCH;
          I_BNOV:   if (!signed_overflow) state_d = S_BRANCH;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_LOAD_RD: state_d = S_LOAD_WR;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b1;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state_q)
      S_FETCH:   ir_enable = 1'b1;
      S_DECODE:  pc_enable = 1'b1;
      S_LOAD_RD: addr_sel  = 1'b0;
      S_LOAD_WR: begin
        addr_sel         = 1'b0;
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        addr_sel         = 1'b0;
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        case (decoded_instruction)
          I_ADD:   operation = 2'b01;
          I_SUB:   operation = 2'b10;
          I_AND:   operation = 2'b11;
          default: operation = 2'b00;
        endcase
      end
      S_MOVE: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_BRANCH: begin
        addr_sel  = 1'b0;
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      S_HALT:    halt = 1'b1;
      default:   ir_enable = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instruction/flag vectors, reset corner
// sequences and random instruction streams against a per-cycle output model.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [1:0] operation;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .ram_write_enable(ram_write_enable),
    .halt(halt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {halt, branch, pc_en, ir_en, addr_sel, c_sel, wr_reg, wr_flags, ram_we, op[1:0]}
  localparam logic [10:0] V_FETCH  = 11'b0_0_0_1_1_0_0_0_0_00;
  localparam logic [10:0] V_DECODE = 11'b0_0_1_0_1_0_0_0_0_00;
  localparam logic [10:0] V_LDRD   = 11'b0_0_0_0_0_0_0_0_0_00;
  localparam logic [10:0] V_LDWR   = 11'b0_0_0_0_0_0_1_0_0_00;
  localparam logic [10:0] V_STORE  = 11'b0_0_0_0_0_0_0_0_1_00;
  localparam logic [10:0] V_MOVE   = 11'b0_0_0_0_1_1_1_0_0_00;
  localparam logic [10:0] V_BRANCH = 11'b0_1_1_0_0_0_0_0_0_00;
  localparam logic [10:0] V_HALT   = 11'b1_0_0_0_1_0_0_0_0_00;

  function automatic logic [10:0] outv();
    return {halt, branch, pc_enable, ir_enable, addr_sel, c_sel,
            write_reg_enable, flags_reg_enable, ram_write_enable, operation};
  endfunction

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Write strobes are mutually exclusive in every cycle.
  always @(negedge clk) begin
    total++;
    if ((int'(write_reg_enable) + int'(ram_write_enable) + int'(pc_enable) + int'(ir_enable)) > 1) begin
      bad++;
      $display("FAIL strobe_exclusive got=%b", outv());
    end
  end

  // Reference: expected per-cycle outputs for one instruction, FETCH through last execute cycle.
  logic [10:0] exp_q[$];
  task automatic build(input decoded_instruction_type ins, input logic z, n, so);
    logic taken;
    logic [10:0] alu;
    exp_q = {};
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    taken = (ins == I_BRANCH) || (ins == I_BZERO && z) || (ins == I_BNZERO && !z) ||
            (ins == I_BNEG && n) || (ins == I_BNNEG && !n) ||
            (ins == I_BOV && so) || (ins == I_BNOV && !so);
    alu = 11'b0_0_0_0_1_1_1_1_0_00;
    case (ins)
      I_LOAD:  begin exp_q.push_back(V_LDRD); exp_q.push_back(V_LDWR); end
      I_STORE: exp_q.push_back(V_STORE);
      I_MOVE:  exp_q.push_back(V_MOVE);
      I_OR:    exp_q.push_back(alu);
      I_ADD:   exp_q.push_back(alu | 11'd1);
      I_SUB:   exp_q.push_back(alu | 11'd2);
      I_AND:   exp_q.push_back(alu | 11'd3);
      default: if (taken) exp_q.push_back(V_BRANCH);
    endcase
  endtask

  // Runs one instruction from a FETCH cycle; returns cycles until next FETCH.
  task automatic run_instr(input decoded_instruction_type ins, input logic z, n, uo, so,
                           input bit wiggle, output int cyc);
    decoded_instruction = ins;
    zero_op = z; neg_op = n; unsigned_overflow = uo; signed_overflow = so;
    build(ins, z, n, so);
    cyc = 0;
    do begin
      if (cyc < exp_q.size()) chk($sformatf("seq_%s_c%0d", ins.name(), cyc), outv(), exp_q[cyc]);
      @(negedge clk);
      cyc++;
      // Flags only matter while decoding; scramble them afterwards.
      if (wiggle && cyc >= 2) begin
        zero_op = 1'($urandom); neg_op = 1'($urandom);
        signed_overflow = 1'($urandom); unsigned_overflow = 1'($urandom);
      end
    end while (!ir_enable && cyc < 8);
    total++;
    if (cyc != exp_q.size()) begin
      bad++;
      $display("FAIL len_%s got=%0d exp=%0d", ins.name(), cyc, exp_q.size());
    end
  endtask

  typedef struct {
    decoded_instruction_type ins;
    logic z, n, uo, so;
    int cycles;
  } vec_t;

  vec_t tbl[16];
  int cyc;

  initial begin
    tbl[0]  = '{I_NOP,    0, 0, 0, 0, 2};
    tbl[1]  = '{I_ADD,    0, 0, 0, 0, 3};
    tbl[2]  = '{I_LOAD,   0, 0, 0, 0, 4};
    tbl[3]  = '{I_STORE,  0, 0, 0, 0, 3};
    tbl[4]  = '{I_MOVE,   1, 1, 1, 1, 3};
    tbl[5]  = '{I_SUB,    0, 0, 0, 0, 3};
    tbl[6]  = '{I_AND,    0, 0, 0, 0, 3};
    tbl[7]  = '{I_OR,     0, 0, 0, 0, 3};
    tbl[8]  = '{I_BRANCH, 0, 0, 0, 0, 3};
    tbl[9]  = '{I_BZERO,  1, 0, 0, 0, 3};
    tbl[10] = '{I_BZERO,  0, 0, 0, 0, 2};
    tbl[11] = '{I_BNZERO, 0, 0, 0, 0, 3};
    tbl[12] = '{I_BNEG,   0, 1, 0, 0, 3};
    tbl[13] = '{I_BNNEG,  0, 1, 0, 0, 2};
    tbl[14] = '{I_BOV,    0, 0, 1, 0, 2};
    tbl[15] = '{I_BNOV,   0, 0, 1, 0, 3};

    decoded_instruction = I_NOP;
    zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hold", outv(), V_FETCH);
    @(negedge clk);
    chk("reset_hold2", outv(), V_FETCH);
    rst_n = 1'b0;
    chk("reset_release", outv(), V_FETCH);

    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].z, tbl[i].n, tbl[i].uo, tbl[i].so, 1'b0, cyc);
      total++;
      if (cyc != tbl[i].cycles) begin
        bad++;
        $display("FAIL cycles_%s got=%0d exp=%0d", tbl[i].ins.name(), cyc, tbl[i].cycles);
      end
    end

    // Halt holds until reset.
    decoded_instruction = I_HALT;
    chk("halt_fetch", outv(), V_FETCH);
    @(negedge clk);
    chk("halt_decode", outv(), V_DECODE);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("halt_hold%0d", k), outv(), V_HALT);
      @(negedge clk);
    end
    rst_n = 1'b1;
    chk("halt_pre_reset", outv(), V_HALT);
    @(negedge clk);
    chk("halt_reset", outv(), V_FETCH);
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    run_instr(I_NOP, 0, 0, 0, 0, 1'b0, cyc);

    // Reset during STORE kills the strobe after the edge.
    decoded_instruction = I_STORE;
    chk("st_fetch", outv(), V_FETCH);
    @(negedge clk);
    chk("st_decode", outv(), V_DECODE);
    @(negedge clk);
    chk("st_store", outv(), V_STORE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("st_after_reset", outv(), V_FETCH);
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    @(negedge clk);
    chk("st_resume_decode", outv(), V_DECODE);
    @(negedge clk);

    // Reset during LOAD_WR likewise.
    decoded_instruction = I_LOAD;
    chk("ld_fetch", outv(), V_FETCH);
    repeat (3) @(negedge clk);
    chk("ld_wr", outv(), V_LDWR);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ld_after_reset", outv(), V_FETCH);
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    run_instr(I_NOP, 0, 0, 0, 0, 1'b0, cyc);

    // Random instruction stream (excluding HALT).
    for (int r = 0; r < 300; r++) begin
      run_instr(decoded_instruction_type'(4'($urandom_range(0, 14))),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk only.
REQ-004 Port: decoded_instruction  input  decoded_instruction_type (k_and_s_pkg)  current IR decode from data path.
REQ-005 Ports: zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered data-path flags.
REQ-006 Ports: branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  output  1 each  data-path controls.
REQ-007 Port: operation  output  2  ALU select: 00 OR, 01 ADD, 10 SUB, 11 AND.
REQ-008 Port: ram_write_enable  output  1  memory write strobe, data = data_out, address = ram_addr.
REQ-009 Port: halt  output  1  high while processor is halted.

Function
REQ-010 The FSM SHALL have states FETCH, DECODE, LOAD_RD, LOAD_WR, STORE, ALU, MOVE, BRANCH, HALT; all outputs Moore, decoded combinationally from state.
REQ-011 Default in every state: all 1-bit outputs 0, operation = 00, addr_sel = 1, unless stated below.
REQ-012 FETCH: addr_sel=1, ir_enable=1; next = DECODE.
REQ-013 DECODE: pc_enable=1, branch=0 (PC+1); next state from decoded_instruction per REQ-014..REQ-018.
REQ-014 I_LOAD -> LOAD_RD; I_STORE -> STORE; I_MOVE -> MOVE; I_ADD/I_SUB/I_AND/I_OR -> ALU; I_HALT -> HALT; I_NOP and any other value -> FETCH.
REQ-015 I_BRANCH -> BRANCH unconditionally.
REQ-016 I_BZERO -> BRANCH if zero_op=1; I_BNZERO -> BRANCH if zero_op=0; else FETCH.
REQ-017 I_BNEG -> BRANCH if neg_op=1; I_BNNEG -> BRANCH if neg_op=0; else FETCH.
REQ-018 I_BOV -> BRANCH if signed_overflow=1; I_BNOV -> BRANCH if signed_overflow=0; else FETCH; unsigned_overflow does not affect branching.
REQ-019 Flag inputs SHALL be sampled in DECODE only (values from previous ALU instruction).
REQ-020 LOAD_RD: addr_sel=0, c_sel=0; next = LOAD_WR.
REQ-021 LOAD_WR: addr_sel=0, c_sel=0, write_reg_enable=1; next = FETCH.
REQ-022 STORE: addr_sel=0, ram_write_enable=1 for exactly one cycle; next = FETCH.
REQ-023 ALU: c_sel=1, write_reg_enable=1, flags_reg_enable=1, operation = 01 ADD / 10 SUB / 11 AND / 00 OR per decoded_instruction; next = FETCH.
REQ-024 MOVE: c_sel=1, write_reg_enable=1, operation=00, flags_reg_enable=0; next = FETCH.
REQ-025 BRANCH: addr_sel=0, branch=1, pc_enable=1 (PC <= mem_addr); next = FETCH.
REQ-026 HALT: halt=1, all other strobes 0; remains in HALT until reset.
REQ-027 Cycle counts per instruction: NOP/untaken branch 2, taken branch 3, ALU/MOVE/STORE 3, LOAD 4.
REQ-028 write_reg_enable, ram_write_enable, pc_enable and ir_enable SHALL never be high in the same cycle as one another except pc_enable with branch.
REQ-029 decoded_instruction SHALL be treated as stable from DECODE until return to FETCH (IR not reloaded outside FETCH).

Reset
REQ-030 rst_n=1 at a rising clk SHALL force state FETCH on that edge, from any state including HALT and mid-instruction.
REQ-031 While in reset and on the first cycle after, outputs SHALL be FETCH values: ir_enable=1, addr_sel=1, all others 0, halt=0.
REQ-032 Reset asserted during STORE or LOAD_WR SHALL suppress the write on the following cycle (no strobe after the reset edge).

Verification
REQ-033 Reset, then I_ADD: FETCH(ir_enable=1) -> DECODE(pc_enable=1) -> ALU(operation=01, c_sel=1, write_reg_enable=1, flags_reg_enable=1) -> FETCH.
REQ-034 I_LOAD: LOAD_RD then LOAD_WR with addr_sel=0, c_sel=0, write_reg_enable=1 only in LOAD_WR; back to FETCH after 4 cycles total.
REQ-035 I_BZERO with zero_op=1 -> BRANCH (branch=1, pc_enable=1, addr_sel=0); repeat with zero_op=0 -> FETCH directly, branch never 1.
REQ-036 I_BOV with signed_overflow=0, unsigned_overflow=1 -> not taken; I_BNOV same flags -> taken.
REQ-037 I_HALT: halt=1 held for 10+ cycles with all strobes 0; assert rst_n=1 one cycle -> FETCH, halt=0.
REQ-038 I_STORE with rst_n=1 asserted in STORE cycle: ram_write_enable=1 only before the reset edge, state FETCH after.
